// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: CPU fetch/data ports plus the shared memory port.
// slave = arbiter side, master = CPU and memory side.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: serialises IF and DM accesses onto one single-port memory.
// Define MEM_ARB_STATS_EN to enable the saturating stall-cycle counters.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_mem_arbiter_if.slave   bus,
    output logic [31:0]         if_stall_cycles,
    output logic [31:0]         dm_stall_cycles
);
    localparam int WA = ADDR_W - 2;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              own_dm_q, own_dm_d;
    logic [WA-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              starved, pick_if, issue;
    logic              if_ack_w, dm_ack_w;
    logic              if_stall_w, dm_stall_w;
    logic              unused_lsb;

    assign unused_lsb = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

    assign starved = starve_q >= SW'(STARVE_MAX);
    assign pick_if = bus.if_req && (!bus.dm_req || starved);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            own_dm_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_dm_q   <= own_dm_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_dm_d   = own_dm_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d  = ISSUE;
                    own_dm_d = !pick_if;
                    if (pick_if) begin
                        addr_d   = bus.if_addr[ADDR_W-1:2];
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        addr_d  = bus.dm_addr[ADDR_W-1:2];
                        we_d    = bus.dm_we;
                        wdata_d = bus.dm_wdata;
                        if (bus.if_req && !starved)
                            starve_d = starve_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 3'(MEM_LAT);
            end
            WAIT: begin
                // mem_rdata is valid in the last WAIT cycle
                if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = ACK;
                    if (!we_q) begin
                        if (own_dm_q) dm_rdata_d = bus.mem_rdata;
                        else          if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign issue    = state_q == ISSUE;
    assign if_ack_w = (state_q == ACK) && !own_dm_q;
    assign dm_ack_w = (state_q == ACK) && own_dm_q;

    // Gated by rst_n so every output reads 0 while reset is held
    assign if_stall_w = rst_n && bus.if_req && !if_ack_w;
    assign dm_stall_w = rst_n && bus.dm_req && !dm_ack_w;

    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue && we_q;
    assign bus.mem_addr  = issue ? addr_q : '0;
    assign bus.mem_wdata = issue ? wdata_q : '0;
    assign bus.if_ack    = if_ack_w;
    assign bus.dm_ack    = dm_ack_w;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_stall  = if_stall_w;
    assign bus.dm_stall  = dm_stall_w;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_stall_cycles <= '0;
            dm_stall_cycles <= '0;
        end else begin
            if (if_stall_w && !(&if_stall_cycles))
                if_stall_cycles <= if_stall_cycles + 32'd1;
            if (dm_stall_w && !(&dm_stall_cycles))
                dm_stall_cycles <= dm_stall_cycles + 32'd1;
        end
    end
`else
    assign if_stall_cycles = '0;
    assign dm_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed vectors, corner sequences and a randomized
// transaction-level reference model for the shared-memory arbiter.
module tb_mips_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    logic [31:0] if_sc, dm_sc, if_sc3, dm_sc3;

    mips_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .if_stall_cycles(if_sc), .dm_stall_cycles(dm_sc)
    );

    mips_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .if_stall_cycles(if_sc3), .dm_stall_cycles(dm_sc3)
    );

    // memory models: read data appears LAT cycles after the mem_en cycle
    logic [31:0] memw [0:63];
    logic [31:0] pipe [0:LAT-1];
    logic [31:0] mem3 [0:63];
    logic [31:0] pipe3 [0:LAT3-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= bus.mem_en ? memw[bus.mem_addr[5:0]] : 32'h0;
        if (bus.mem_en && bus.mem_we) memw[bus.mem_addr[5:0]] = bus.mem_wdata;
    end

    always @(posedge clk) begin
        for (int i = LAT3 - 1; i > 0; i--) pipe3[i] <= pipe3[i-1];
        pipe3[0] <= bus3.mem_en ? mem3[bus3.mem_addr[5:0]] : 32'h0;
    end

    assign bus.mem_rdata  = pipe[LAT-1];
    assign bus3.mem_rdata = pipe3[LAT3-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus3.if_req = 1'b0;
        bus3.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [29:0] exp_ma;
        logic        exp_we;
    } vec_t;

    vec_t vt [6];

    task automatic run_vec(input vec_t v);
        int n, en_at, ack_at, st_cnt;
        logic ack, st;
        @(posedge clk); #1;
        bus.dm_we    = v.we;
        bus.dm_addr  = v.addr;
        bus.dm_wdata = v.wdata;
        bus.if_addr  = v.addr;
        if (v.dm) bus.dm_req = 1'b1;
        else      bus.if_req = 1'b1;
        #1;
        chk("v_stall_c0", v.dm ? bus.dm_stall : bus.if_stall, 1'b1);
        n = 0; en_at = -1; ack_at = -1; st_cnt = 1;
        while (ack_at < 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_en) begin
                en_at = n;
                chk("v_mem_addr", bus.mem_addr, v.exp_ma);
                chk("v_mem_we", bus.mem_we, v.exp_we);
            end
            ack = v.dm ? bus.dm_ack : bus.if_ack;
            st  = v.dm ? bus.dm_stall : bus.if_stall;
            if (ack) begin
                ack_at = n;
                chk("v_rdata", v.dm ? bus.dm_rdata : bus.if_rdata, v.exp_rd);
                chk("v_stall_ack", st, 1'b0);
            end else if (st) begin
                st_cnt++;
            end
        end
        chk("v_en_cycle", en_at, 1);
        chk("v_ack_cycle", ack_at, LAT + 2);
        chk("v_stall_cycles", st_cnt, LAT + 2);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    logic [31:0] refm [0:63];

    initial begin
        int n, g, sc, ens, ack_at;
        int free_c, en_c, ack_c, starve, a;
        logic own_dm, p_we, e_en, e_ia, e_da;
        logic if_act, dm_act, if_rel, dm_rel;
        logic [29:0] p_ma;
        logic [31:0] p_wd, exp_if_rd, exp_dm_rd;

        for (int i = 0; i < 64; i++) begin
            memw[i] = 32'hA500_0000 + i * 32'h0001_0203;
            mem3[i] = 32'h5A00_0000 + i;
        end
        memw[2] = 32'h8C04_0002;
        mem3[5] = 32'h1234_5678;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0;
        bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus3.if_req = 0; bus3.if_addr = 0; bus3.dm_req = 0;
        bus3.dm_we = 0; bus3.dm_addr = 0; bus3.dm_wdata = 0;

        #1;
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_if_ack", bus.if_ack, 1'b0);
        chk("rst_dm_ack", bus.dm_ack, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vt[0] = '{1'b0, 1'b0, 32'h8,  32'h0,        32'h8C04_0002, 30'd2, 1'b0};
        vt[1] = '{1'b1, 1'b1, 32'hC,  32'h6,        32'h0,         30'd3, 1'b1};
        vt[2] = '{1'b1, 1'b0, 32'hC,  32'h0,        32'h6,         30'd3, 1'b0};
        vt[3] = '{1'b1, 1'b0, 32'hF,  32'h0,        32'h6,         30'd3, 1'b0};
        vt[4] = '{1'b1, 1'b1, 32'h21, 32'hDEADBEEF, 32'h6,         30'd8, 1'b1};
        vt[5] = '{1'b0, 1'b1, 32'h22, 32'h0,        32'hDEADBEEF,  30'd8, 1'b0};
        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // reset while an IF read sits in WAIT
        @(posedge clk); #1;
        bus.if_addr = 32'h8;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        chk("rw_issue", bus.mem_en, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rw_if_ack", bus.if_ack, 1'b0);
        chk("rw_if_rdata", bus.if_rdata, 32'h0);
        chk("rw_dm_rdata", bus.dm_rdata, 32'h0);
        chk("rw_mem_en", bus.mem_en, 1'b0);
        chk("rw_if_stall", bus.if_stall, 1'b0);
        @(posedge clk); #1;
        chk("rw_no_ack", bus.if_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; ack_at = -1;
        while (ack_at < 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.if_ack) ack_at = n;
        end
        chk("rw_fresh_ack", ack_at, LAT + 2);
        chk("rw_fresh_rdata", bus.if_rdata, 32'h8C04_0002);
        bus.if_req = 1'b0;

        // both requesters held: IF forced in after STARVE_MAX DM grants
        do_reset();
        @(posedge clk); #1;
        bus.if_addr = 32'h10;
        bus.dm_addr = 32'h20;
        bus.dm_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        g = 0; sc = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (bus.if_stall) sc++;
            if (bus.dm_stall) sc++;
            if (bus.mem_en && g < 10) begin
                chk("starve_order", bus.mem_addr, (g % 5 == 4) ? 30'd4 : 30'd8);
                g++;
            end
            @(posedge clk); #1;
            if (k == 19) begin
`ifdef MEM_ARB_STATS_EN
                chk("stats_sum", if_sc + dm_sc, sc);
`else
                chk("stats_if_tied", if_sc, 32'h0);
                chk("stats_dm_tied", dm_sc, 32'h0);
`endif
            end
        end
        chk("starve_grants", g, 10);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;

        // MEM_LAT=3 single load
        @(posedge clk); #1;
        bus3.dm_addr = 32'h14;
        bus3.dm_we   = 1'b0;
        bus3.dm_req  = 1'b1;
        n = 0; ens = 0; ack_at = -1;
        while (ack_at < 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus3.mem_en) ens++;
            if (bus3.dm_ack) ack_at = n;
        end
        chk("lat3_ack", ack_at, LAT3 + 2);
        chk("lat3_single_en", ens, 1);
        chk("lat3_rdata", bus3.dm_rdata, 32'h1234_5678);
        bus3.dm_req = 1'b0;

        // randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 64; i++) refm[i] = memw[i];
        free_c = 0; en_c = -1; ack_c = -1; starve = 0;
        own_dm = 0; p_we = 0; p_ma = 0; p_wd = 0;
        exp_if_rd = 0; exp_dm_rd = 0;
        if_act = 0; dm_act = 0; if_rel = 0; dm_rel = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            e_en = (c == en_c);
            e_ia = (c == ack_c) && !own_dm;
            e_da = (c == ack_c) && own_dm;
            chk("r_mem_en", bus.mem_en, e_en);
            if (e_en) begin
                chk("r_mem_addr", bus.mem_addr, p_ma);
                chk("r_mem_we", bus.mem_we, p_we);
                if (p_we) chk("r_mem_wdata", bus.mem_wdata, p_wd);
            end
            chk("r_if_ack", bus.if_ack, e_ia);
            chk("r_dm_ack", bus.dm_ack, e_da);
            if (e_ia) chk("r_if_rdata", bus.if_rdata, exp_if_rd);
            if (e_da) chk("r_dm_rdata", bus.dm_rdata, exp_dm_rd);
            if (if_rel) begin if_act = 0; if_rel = 0; end
            if (dm_rel) begin dm_act = 0; dm_rel = 0; end
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1;
                a = $urandom_range(0, 255);
                bus.if_addr = 32'(a);
            end
            if (!dm_act && $urandom_range(0, 2) == 0) begin
                dm_act = 1;
                a = $urandom_range(0, 255);
                bus.dm_addr  = 32'(a);
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_wdata = $urandom;
            end
            bus.if_req = if_act;
            bus.dm_req = dm_act;
            if (c >= free_c && (if_act || dm_act)) begin
                own_dm = dm_act && !(if_act && starve >= SMAX);
                if (own_dm) begin
                    if (if_act && starve < SMAX) starve++;
                    p_ma = 30'(bus.dm_addr >> 2);
                    p_we = bus.dm_we;
                    p_wd = bus.dm_wdata;
                end else begin
                    starve = 0;
                    p_ma = 30'(bus.if_addr >> 2);
                    p_we = 0;
                    p_wd = 0;
                end
                if (p_we)        refm[p_ma[5:0]] = p_wd;
                else if (own_dm) exp_dm_rd = refm[p_ma[5:0]];
                else             exp_if_rd = refm[p_ma[5:0]];
                en_c   = c + 1;
                ack_c  = c + LAT + 2;
                free_c = ack_c + 1;
            end
            if (e_ia) if_rel = 1;
            if (e_da) dm_rel = 1;
            #1;
            chk("r_if_stall", bus.if_stall, if_act && !e_ia);
            chk("r_dm_stall", bus.dm_stall, dm_act && !e_da);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
